// File: rtl/booth_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states and add/sub op-select.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } op_t;

  // Radix-2 Booth recoding of the current multiplier bit pair {Q0, q-1}.
  function automatic op_t booth_op(input logic q0, input logic qm1);
    case ({q0, qm1})
      2'b10:   return OP_SUB;
      2'b01:   return OP_ADD;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// Combinational accumulator update: A, A+M or A-M, wrapping modulo 2^W.
module booth_addsub
  import booth_pkg::*;
#(
  parameter int W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] m,
  input  op_t          op,
  output logic [W-1:0] sum
);

  always_comb begin
    sum = a;
    case (op)
      OP_ADD:  sum = a + m;
      OP_SUB:  sum = a - m;
      default: sum = a;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier, signed/unsigned, with valid/ready on both sides.
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           is_signed,
  input  logic [W-1:0]   mcand,
  input  logic [W-1:0]   mplier,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int CW = $clog2(W + 2);

  state_t        state;
  logic [W:0]    a;
  logic [W:0]    q;
  logic [W:0]    m;
  logic          qm1;
  logic [CW-1:0] count;
  logic [W:0]    sum;
  op_t           op;

  // One extra operand bit lets the same signed Booth datapath handle unsigned inputs.
  function automatic logic [W:0] extend(input logic [W-1:0] v, input logic sgn);
    return sgn ? {v[W-1], v} : {1'b0, v};
  endfunction

  assign op = booth_op(q[0], qm1);

  booth_addsub #(
    .W(W + 1)
  ) u_addsub (
    .a  (a),
    .m  (m),
    .op (op),
    .sum(sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      a         <= '0;
      q         <= '0;
      m         <= '0;
      qm1       <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            m        <= extend(mcand, is_signed);
            q        <= extend(mplier, is_signed);
            a        <= '0;
            qm1      <= 1'b0;
            count    <= CW'(W + 1);
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          if (count != '0) begin
            a     <= {sum[W], sum[W:1]};
            q     <= {sum[0], q[W:1]};
            qm1   <= q[0];
            count <= count - CW'(1);
          end else begin
            // Low 2*W bits of {A,Q}; the top two bits are pure sign extension.
            product   <= {a[W-2:0], q};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq (W=16): directed vectors, back-pressure, mid-op reset.
module tb_booth_mul_seq;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           is_signed = 1'b0;
  logic [W-1:0]   mcand = '0;
  logic [W-1:0]   mplier = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] product;
  logic           busy;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];

  booth_mul_seq #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .is_signed(is_signed),
    .mcand    (mcand),
    .mplier   (mplier),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Monitor: every output handshake pops one expected product.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got %h expected none", product);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        if (product !== e) begin
          bad++;
          $display("FAIL product: got %h expected %h", product, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operand pair; returns edges from accept until out_valid rises.
  task automatic issue(input logic sgn, input logic [W-1:0] mc, input logic [W-1:0] mp,
                       input logic [2*W-1:0] want, input logic push, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    is_signed = sgn;
    mcand     = mc;
    mplier    = mp;
    in_valid  = 1'b1;
    if (push) exp_q.push_back(want);
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  typedef struct {
    logic           sgn;
    logic [W-1:0]   mc;
    logic [W-1:0]   mp;
    logic [2*W-1:0] prod;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat;
    vecs.push_back('{1'b1, 16'h0003, 16'hFFFB, 32'hFFFF_FFF1});
    vecs.push_back('{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001});
    vecs.push_back('{1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001});
    vecs.push_back('{1'b1, 16'h8000, 16'h8000, 32'h4000_0000});
    vecs.push_back('{1'b1, 16'h8000, 16'h0001, 32'hFFFF_8000});
    vecs.push_back('{1'b0, 16'h8000, 16'h0002, 32'h0001_0000});
    vecs.push_back('{1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001});
    vecs.push_back('{1'b1, 16'hFFFF, 16'h7FFF, 32'hFFFF_8001});
    vecs.push_back('{1'b0, 16'h1234, 16'h0010, 32'h0001_2340});
    vecs.push_back('{1'b1, 16'h0000, 16'h1234, 32'h0000_0000});
    vecs.push_back('{1'b0, 16'h1234, 16'h0000, 32'h0000_0000});

    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_product", product, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      issue(vecs[i].sgn, vecs[i].mc, vecs[i].mp, vecs[i].prod, 1'b1, lat);
      if (i == 0) chk("latency", lat, W + 2);
      step();
    end

    // Back-pressure: hold DONE for 10 cycles while poking in_valid.
    out_ready = 1'b0;
    issue(1'b0, 16'd100, 16'd200, 32'd20000, 1'b1, lat);
    chk("bp_reached_done", lat < 100, 1);
    chk("bp_busy", busy, 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      mcand    = 16'h5555;
      mplier   = 16'hAAAA;
      step();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_product", product, 32'd20000);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk("after_hs_in_ready", in_ready, 1);
    chk("after_hs_busy", busy, 0);

    // Reset in the 7th CALC cycle; the aborted op is never presented.
    issue_abort();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < W + 5; i++) begin
      step();
      if (out_valid) chk("abort_no_output", out_valid, 0);
    end
    issue(1'b0, 16'd7, 16'd6, 32'd42, 1'b1, lat);
    chk("post_reset_latency", lat, W + 2);
    step();

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic issue_abort();
    is_signed = 1'b1;
    mcand     = 16'h1111;
    mplier    = 16'h2222;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("abort_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_product", product, 0);
  endtask

endmodule
